// File: rtl/ram64b_read_port.sv
// -----------------------------------------------------------------------------
// ram64b_read_port
//
// Read-side controller for the 32x64 register RAM. It accepts read requests
// on a valid/ready channel, drives the RAM's synchronous read address (the RAM
// read clock is clk_i), and returns read data on a valid/ready response
// channel. It sustains one read per cycle. The block sits between
// decode/operand fetch and the RAM read port.
//
// Pipeline
//   S1  : RAM access stage (r_s1_v, r_s1_addr). The RAM is addressed on the
//         edge that accepts a request. Its data is valid one cycle later.
//   RSP : response register (r_rsp_v, r_rsp_data). It holds a snapshot of
//         the selected read data until the consumer takes it.
//
// Parameters
//   DW        data width; must match the RAM rdata/wdata width
//   AW        address width; the RAM has 2**AW entries
//   ZERO_REG  1: address 0 always reads as zero and the RAM data is ignored
//
// Ports
//   clk_i        in   1    clock; also drives the RAM read clock
//   reset_ni     in   1    asynchronous reset, active low
//   req_valid_i  in   1    read request valid
//   req_ready_o  out  1    request accepted when valid && ready at a rising edge
//   req_addr_i   in   AW   read address
//   rsp_valid_o  out  1    response data valid
//   rsp_ready_i  in   1    consumer takes the response when valid && ready
//   rsp_data_o   out  DW   read data; stable while valid && !ready
//   raddr_o      out  AW   RAM read address
//   rdata_i      in   DW   RAM read data, valid one cycle after raddr is sampled
//   wen_i        in   1    snoop: RAM write enable
//   waddr_i      in   AW   snoop: RAM write address
//   wdata_i      in   DW   snoop: RAM write data
//
// Build option
//   RAM64B_READ_BYPASS_EN  When this macro is defined, writes that target the
//                          address being read are forwarded. A read then sees
//                          a write issued in the same cycle, or a write issued
//                          while the read is still pending. When the macro is
//                          undefined, the forwarding path is not built, and a
//                          read-during-write to the same address returns
//                          whatever the RAM produces.
// -----------------------------------------------------------------------------
module ram64b_read_port #(
    parameter int DW       = 64,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,

    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [AW-1:0] req_addr_i,

    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_data_o,

    output logic [AW-1:0] raddr_o,
    input  logic [DW-1:0] rdata_i,

    input  logic          wen_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic          r_s1_v;
    logic [AW-1:0] r_s1_addr;
    logic          r_rsp_v;
    logic [DW-1:0] r_rsp_data;

    logic          w_s1_v_next;
    logic [AW-1:0] w_s1_addr_next;
    logic          w_rsp_v_next;
    logic [DW-1:0] w_rsp_data_next;

    logic          w_acc;        // request accepted at this edge
    logic          w_adv;        // S1 moves into RSP at this edge
    logic          w_zero_hit;   // S1 holds the hard-wired zero register
    logic          w_fwd_v;      // forwarded write data is valid for S1
    logic [DW-1:0] w_fwd_data;
    logic [DW-1:0] w_sel;        // data that RSP captures on advance

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // S1 can take a new request in three cases: S1 is empty, RSP is empty,
    // or RSP is draining this cycle. In the last two cases S1 advances on the
    // same edge, so a full S1 is refilled rather than emptied. This depends
    // combinationally on rsp_ready_i, which keeps throughput at one read per
    // cycle.
    assign req_ready_o = !r_s1_v || !r_rsp_v || rsp_ready_i;

    // While reset is asserted, no request is taken. This keeps raddr_o at its
    // reset value even if a requester presents valid during reset.
    assign w_acc = req_valid_i && req_ready_o && reset_ni;
    assign w_adv = r_s1_v && (!r_rsp_v || rsp_ready_i);

    // The RAM sees the new address on an accepting edge. Otherwise it keeps
    // re-reading the address held in S1. A stalled S1 therefore always has
    // current rdata_i when it finally advances.
    assign raddr_o = w_acc ? req_addr_i : r_s1_addr;

    assign rsp_valid_o = r_rsp_v;
    assign rsp_data_o  = r_rsp_data;

    // -------------------------------------------------------------------------
    // Zero-register detect
    // -------------------------------------------------------------------------
    generate
        if (ZERO_REG != 0) begin : g_zero_reg
            assign w_zero_hit = (r_s1_addr == '0);
        end else begin : g_no_zero_reg
            assign w_zero_hit = 1'b0;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read-during-write forwarding
    // -------------------------------------------------------------------------
`ifdef RAM64B_READ_BYPASS_EN
    logic          r_fwd_v;
    logic [DW-1:0] r_fwd_data;
    logic          w_fwd_hit;

    // The comparison uses the address the RAM is reading this cycle, which
    // is either the new request or the stalled S1 address. A write to that
    // address would be missed by the read-first RAM, so it is captured here.
    // The capture repeats on every matching write while S1 stalls, so the
    // newest write always wins.
    assign w_fwd_hit = wen_i && (waddr_i == raddr_o);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_fwd_v    <= 1'b0;
            r_fwd_data <= '0;
        end else if (w_fwd_hit) begin
            r_fwd_v    <= 1'b1;
            r_fwd_data <= wdata_i;
        end else if (w_acc || w_adv) begin
            // Either a new address without a matching write has entered S1,
            // or S1 has been vacated. In both cases the captured data is stale.
            r_fwd_v    <= 1'b0;
        end
    end

    assign w_fwd_v    = r_fwd_v;
    assign w_fwd_data = r_fwd_data;
`else
    // Forwarding is absent. The snoop port is intentionally left unobserved.
    logic w_unused_snoop;
    assign w_unused_snoop = ^{wen_i, waddr_i, wdata_i};

    assign w_fwd_v    = 1'b0;
    assign w_fwd_data = '0;
`endif

    // -------------------------------------------------------------------------
    // Response data select
    // -------------------------------------------------------------------------
    // Precedence is: the zero register first, then forwarded write data,
    // then RAM data.
    always_comb begin
        w_sel = rdata_i;
        if (w_zero_hit) begin
            w_sel = '0;
        end else if (w_fwd_v) begin
            w_sel = w_fwd_data;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_s1_v_next     = r_s1_v;
        w_s1_addr_next  = r_s1_addr;
        w_rsp_v_next    = r_rsp_v;
        w_rsp_data_next = r_rsp_data;

        // S1: accepting takes priority over emptying, so an S1 that advances
        // and accepts on the same edge stays full.
        if (w_acc) begin
            w_s1_v_next    = 1'b1;
            w_s1_addr_next = req_addr_i;
        end else if (w_adv) begin
            w_s1_v_next    = 1'b0;
        end

        // RSP: data is only captured on advance. A held response is never
        // touched by later RAM writes.
        if (w_adv) begin
            w_rsp_v_next    = 1'b1;
            w_rsp_data_next = w_sel;
        end else if (rsp_ready_i) begin
            w_rsp_v_next    = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_s1_v     <= 1'b0;
            r_s1_addr  <= '0;
            r_rsp_v    <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            r_s1_v     <= w_s1_v_next;
            r_s1_addr  <= w_s1_addr_next;
            r_rsp_v    <= w_rsp_v_next;
            r_rsp_data <= w_rsp_data_next;
        end
    end

endmodule
